// File: rtl/satir_kaydirma_hatli_pkg.sv
// Shared constants, FSM state type and row-offset helper for the ShiftRows datapath.
// Rijndael block widths from 128 to 256 bits are covered by NB_MIN..NB_MAX.
package aes_paket;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;

    typedef enum logic [1:0] {
        BOS  = 2'd0,
        TEK  = 2'd1,
        DOLU = 2'd2
    } durum_t;

    function automatic bit nb_gecerli(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // The 256-bit block skips offset 2: rows 2 and 3 rotate by 3 and 4.
    function automatic int satir_ofset(input int nb, input int r);
        if (nb == 8 && r >= 2)
            return r + 1;
        return r;
    endfunction

endpackage

// File: rtl/satir_kaydirma_hatli_if.sv
// Valid/ready bus between the key-add/S-box stage, the ShiftRows unit and MixColumns.
// The slave modport is the ShiftRows unit; the master modport is its surroundings.
interface satir_kaydirma_hatli_if #(
    parameter int NB = 4
) ();

    localparam int W = 32 * NB;

    logic         giris_gecerli;
    logic         giris_hazir;
    logic [W-1:0] matris;
    logic         ters;
    logic         cikis_gecerli;
    logic         cikis_hazir;
    logic [W-1:0] kaydirilmis_matris;
    logic         cikis_ters;
    logic [15:0]  blok_sayisi;

    modport master (
        output giris_gecerli,
        input  giris_hazir,
        output matris,
        output ters,
        input  cikis_gecerli,
        output cikis_hazir,
        input  kaydirilmis_matris,
        input  cikis_ters,
        input  blok_sayisi
    );

    modport slave (
        input  giris_gecerli,
        output giris_hazir,
        input  matris,
        input  ters,
        output cikis_gecerli,
        input  cikis_hazir,
        output kaydirilmis_matris,
        output cikis_ters,
        output blok_sayisi
    );

endinterface

// File: rtl/satir_kaydirma_hatli_nb.sv
// Combinational ShiftRows / InvShiftRows for an NB-column Rijndael state.
// Column 0 sits in the MSBs and row 0 is the top byte of each column.
module satir_kaydirma_nb
    import aes_paket::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] matris,
    input  logic             ters,
    output logic [32*NB-1:0] kaydirilmis
);

    localparam int W = 32 * NB;

    logic [W-1:0] ileri;
    logic [W-1:0] geri;

    // Both directions are pure wiring; only the final mux costs logic.
    for (genvar c = 0; c < NB; c++) begin : g_sutun
        for (genvar r = 0; r < 4; r++) begin : g_satir
            localparam int OFS      = satir_ofset(NB, r);
            localparam int ILERI_KA = (c + OFS) % NB;
            localparam int GERI_KA  = (c + NB - OFS) % NB;
            localparam int HEDEF    = W - 1 - 32 * c - 8 * r;
            localparam int KAYNAK_I = W - 1 - 32 * ILERI_KA - 8 * r;
            localparam int KAYNAK_G = W - 1 - 32 * GERI_KA - 8 * r;

            assign ileri[HEDEF -: 8] = matris[KAYNAK_I -: 8];
            assign geri[HEDEF -: 8]  = matris[KAYNAK_G -: 8];
        end
    end

    assign kaydirilmis = ters ? geri : ileri;

endmodule

// File: rtl/satir_kaydirma_hatli.sv
// Registered ShiftRows / InvShiftRows stage with a 2-entry skid buffer.
// Register A drives the outputs; B catches one block when the output stalls.
module satir_kaydirma_hatli
    import aes_paket::*;
#(
    parameter int NB = 4
) (
    input logic                  clk,
    input logic                  rst,
    satir_kaydirma_hatli_if.slave bus
);

    localparam int W = 32 * NB;

    if (!nb_gecerli(NB)) begin : g_nb_hatasi
        $error("satir_kaydirma_hatli: NB must be 4, 6 or 8");
    end

    durum_t       durum;
    logic [W-1:0] a_blok;
    logic         a_ters;
    logic [W-1:0] b_blok;
    logic         b_ters;
    logic [15:0]  sayac;
    logic [W-1:0] kaydirilmis;
    logic         kabul;
    logic         teslim;

    satir_kaydirma_nb #(
        .NB (NB)
    ) u_kaydirma (
        .matris      (bus.matris),
        .ters        (bus.ters),
        .kaydirilmis (kaydirilmis)
    );

    assign bus.giris_hazir   = (durum != DOLU) & ~rst;
    assign bus.cikis_gecerli = (durum != BOS);
    assign kabul             = bus.giris_gecerli & bus.giris_hazir;
    assign teslim            = bus.cikis_gecerli & bus.cikis_hazir;

    // A only changes when it is empty or its block is leaving, which keeps a stalled output frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum  <= BOS;
            a_blok <= '0;
            a_ters <= 1'b0;
            b_blok <= '0;
            b_ters <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (kabul) begin
                        a_blok <= kaydirilmis;
                        a_ters <= bus.ters;
                        durum  <= TEK;
                    end
                end
                TEK: begin
                    if (kabul && teslim) begin
                        a_blok <= kaydirilmis;
                        a_ters <= bus.ters;
                    end else if (kabul) begin
                        b_blok <= kaydirilmis;
                        b_ters <= bus.ters;
                        durum  <= DOLU;
                    end else if (teslim) begin
                        durum  <= BOS;
                    end
                end
                DOLU: begin
                    if (teslim) begin
                        a_blok <= b_blok;
                        a_ters <= b_ters;
                        durum  <= TEK;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sayac <= '0;
        else if (teslim)
            sayac <= sayac + 16'd1;
    end

    assign bus.kaydirilmis_matris = a_blok;
    assign bus.cikis_ters         = a_ters;
    assign bus.blok_sayisi        = sayac;

endmodule

// File: tb/tb_satir_kaydirma_hatli.sv
// Directed bench for satir_kaydirma_hatli: vector table for NB=4, spot checks for NB=8,
// plus hand-written back-pressure, reset-in-DOLU and counter-wrap sequences.
module tb_satir_kaydirma_hatli;

    typedef struct {
        logic [127:0] girdi;
        logic         ters;
        logic [127:0] beklenen;
    } vektor_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    vektor_t      tablo [6];
    logic [255:0] girdi8;

    satir_kaydirma_hatli_if #(.NB(4)) bus4 ();
    satir_kaydirma_hatli_if #(.NB(8)) bus8 ();

    satir_kaydirma_hatli #(.NB(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    satir_kaydirma_hatli #(.NB(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string ad, input logic [255:0] gercek, input logic [255:0] beklenen);
        total++;
        if (gercek !== beklenen) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
        end
    endtask

    task automatic apply_stimulus(input logic gecerli, input logic [127:0] blok, input logic t);
        bus4.giris_gecerli = gecerli;
        bus4.matris        = blok;
        bus4.ters          = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_output("rst_gecerli", 256'(bus4.cikis_gecerli), 256'd0);
        check_output("rst_veri", 256'(bus4.kaydirilmis_matris), 256'd0);
        check_output("rst_ters", 256'(bus4.cikis_ters), 256'd0);
        check_output("rst_sayac", 256'(bus4.blok_sayisi), 256'd0);
        check_output("rst_hazir", 256'(bus4.giris_hazir), 256'd0);
        rst = 1'b0;
        #1;
        check_output("rst_sonra_hazir", 256'(bus4.giris_hazir), 256'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        apply_stimulus(1'b0, 128'd0, 1'b0);
        bus4.cikis_hazir   = 1'b1;
        bus8.giris_gecerli = 1'b0;
        bus8.matris        = '0;
        bus8.ters          = 1'b0;
        bus8.cikis_hazir   = 1'b1;

        tablo[0] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0, 128'h00050a0f_04090e03_080d0207_0c01060b};
        tablo[1] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, 128'h000d0a07_04010e0b_0805020f_0c090603};
        tablo[2] = '{128'h00050a0f_04090e03_080d0207_0c01060b, 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f};
        tablo[3] = '{128'h10203040_11213141_12223242_13233343, 1'b0, 128'h10213243_11223340_12233041_13203142};
        tablo[4] = '{128'h10203040_11213141_12223242_13233343, 1'b1, 128'h10233241_11203342_12213043_13223140};
        tablo[5] = '{128'h10233241_11203342_12213043_13223140, 1'b0, 128'h10203040_11213141_12223242_13233343};

        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                girdi8[255 - 32 * c - 8 * r -: 8] = 8'(4 * c + r);

        tick();
        do_reset();

        // Back-to-back mixed-direction stream with the output always ready.
        bus4.cikis_hazir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, tablo[i].girdi, tablo[i].ters);
            tick();
            check_output($sformatf("tablo%0d_gecerli", i), 256'(bus4.cikis_gecerli), 256'd1);
            check_output($sformatf("tablo%0d_veri", i), 256'(bus4.kaydirilmis_matris), 256'(tablo[i].beklenen));
            check_output($sformatf("tablo%0d_ters", i), 256'(bus4.cikis_ters), 256'(tablo[i].ters));
            check_output($sformatf("tablo%0d_hazir", i), 256'(bus4.giris_hazir), 256'd1);
        end
        apply_stimulus(1'b0, 128'd0, 1'b0);
        tick();
        check_output("tablo_bos", 256'(bus4.cikis_gecerli), 256'd0);
        check_output("tablo_sayac", 256'(bus4.blok_sayisi), 256'd6);

        // NB=8 forward then inverse.
        bus8.giris_gecerli = 1'b1;
        bus8.matris        = girdi8;
        bus8.ters          = 1'b0;
        tick();
        check_output("nb8_ileri", 256'(bus8.kaydirilmis_matris[255:192]), 256'h00050e13_04091217);
        bus8.ters = 1'b1;
        tick();
        check_output("nb8_geri", 256'(bus8.kaydirilmis_matris[255:192]), 256'h001d1613_04011a17);
        check_output("nb8_geri_ters", 256'(bus8.cikis_ters), 256'd1);
        bus8.giris_gecerli = 1'b0;
        tick();
        check_output("nb8_sayac", 256'(bus8.blok_sayisi), 256'd2);

        // Back-pressure: three blocks against a stalled output.
        do_reset();
        bus4.cikis_hazir = 1'b0;
        apply_stimulus(1'b1, tablo[0].girdi, tablo[0].ters);
        tick();
        check_output("bp_hazir_tek", 256'(bus4.giris_hazir), 256'd1);
        apply_stimulus(1'b1, tablo[1].girdi, tablo[1].ters);
        tick();
        check_output("bp_hazir_dolu", 256'(bus4.giris_hazir), 256'd0);
        check_output("bp_veri1", 256'(bus4.kaydirilmis_matris), 256'(tablo[0].beklenen));
        apply_stimulus(1'b1, tablo[3].girdi, tablo[3].ters);
        tick();
        check_output("bp_donuk_veri", 256'(bus4.kaydirilmis_matris), 256'(tablo[0].beklenen));
        check_output("bp_donuk_ters", 256'(bus4.cikis_ters), 256'd0);
        check_output("bp_donuk_hazir", 256'(bus4.giris_hazir), 256'd0);
        bus4.cikis_hazir = 1'b1;
        tick();
        check_output("bp_veri2", 256'(bus4.kaydirilmis_matris), 256'(tablo[1].beklenen));
        check_output("bp_ters2", 256'(bus4.cikis_ters), 256'd1);
        check_output("bp_hazir_geri", 256'(bus4.giris_hazir), 256'd1);
        tick();
        check_output("bp_veri3", 256'(bus4.kaydirilmis_matris), 256'(tablo[3].beklenen));
        apply_stimulus(1'b0, 128'd0, 1'b0);
        tick();
        check_output("bp_bos", 256'(bus4.cikis_gecerli), 256'd0);
        check_output("bp_sayac", 256'(bus4.blok_sayisi), 256'd3);

        // Reset while DOLU discards both held blocks.
        bus4.cikis_hazir = 1'b0;
        apply_stimulus(1'b1, tablo[3].girdi, tablo[3].ters);
        tick();
        apply_stimulus(1'b1, tablo[4].girdi, tablo[4].ters);
        tick();
        apply_stimulus(1'b0, 128'd0, 1'b0);
        check_output("rd_dolu", 256'(bus4.giris_hazir), 256'd0);
        rst = 1'b1;
        tick();
        check_output("rd_gecerli", 256'(bus4.cikis_gecerli), 256'd0);
        check_output("rd_veri", 256'(bus4.kaydirilmis_matris), 256'd0);
        check_output("rd_sayac", 256'(bus4.blok_sayisi), 256'd0);
        check_output("rd_hazir_rst", 256'(bus4.giris_hazir), 256'd0);
        rst = 1'b0;
        bus4.cikis_hazir = 1'b1;
        tick();
        check_output("rd_hazir_sonra", 256'(bus4.giris_hazir), 256'd1);
        check_output("rd_b_atildi", 256'(bus4.cikis_gecerli), 256'd0);

        // Counter wrap after 65535 streamed handshakes.
        apply_stimulus(1'b1, tablo[0].girdi, 1'b0);
        repeat (65535) @(posedge clk);
        #1;
        apply_stimulus(1'b0, 128'd0, 1'b0);
        tick();
        check_output("sayac_ffff", 256'(bus4.blok_sayisi), 256'hffff);
        apply_stimulus(1'b1, tablo[3].girdi, 1'b0);
        tick();
        apply_stimulus(1'b0, 128'd0, 1'b0);
        tick();
        check_output("sayac_sarma", 256'(bus4.blok_sayisi), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/satir_kaydirma_hatli.md
# satir_kaydirma_hatli

Parametrised, registered ShiftRows / InvShiftRows unit for the AES/Rijndael datapath. It accepts one state block per cycle over a valid/ready handshake and applies the forward or inverse row rotation selected per beat. It generalises the block width to Rijndael Nb = 4, 6 or 8 columns and returns the result through a 2-entry skid buffer, so upstream (key add / S-box) and downstream (MixColumns) stages can stall independently at full throughput.

## Interface
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8. Any other value is an elaboration error.
- W, 32*NB, block width (derived; not overridable).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- giris_gecerli  in  1  input block valid.
- giris_hazir  out  1  block can be accepted this cycle.
- matris  in  W  input state. Column 0 is in the MSBs; within each column, row 0 is in the top byte.
- ters  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the block.
- cikis_gecerli  out  1  output block valid.
- cikis_hazir  in  1  downstream accepts.
- kaydirilmis_matris  out  W  shifted state, same layout as `matris`.
- cikis_ters  out  1  `ters` value that travelled with the block.
- blok_sayisi  out  16  count of completed output handshakes.

## Operation
- Shift offsets per row r0..r3:
  - NB=4 and NB=6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: output column c, row r = input column (c + off_r) mod NB, row r.
- Inverse: output column c, row r = input column (c − off_r) mod NB, row r.
- The shift is purely combinational on `matris` and `ters`. Only the shifted result and its `ters` tag are stored.
- Input handshake = `giris_gecerli & giris_hazir`. Output handshake = `cikis_gecerli & cikis_hazir`.
- Storage: main register A drives the outputs; skid register B holds a block when the output stalls.
- State machine `durum`:
  - BOS: accept → TEK, load A.
  - TEK, accept and output taken → TEK, reload A.
  - TEK, accept and output stalled → DOLU, load B.
  - TEK, no accept and output taken → BOS.
  - TEK, otherwise → hold.
  - DOLU: output taken → TEK, A ← B. Otherwise hold.
- Output and ready decoding:
  - `cikis_gecerli` = (durum ≠ BOS).
  - `giris_hazir` = (durum ≠ DOLU) & ~rst.
- Data stability: while `cikis_gecerli` is high and `cikis_hazir` is low, `kaydirilmis_matris` and `cikis_ters` stay frozen.
- `blok_sayisi` increments by 1 per output handshake and wraps from 16'hFFFF to 0.
- Reset values: durum = BOS, `cikis_gecerli` = 0, `kaydirilmis_matris` = 0, `cikis_ters` = 0, `blok_sayisi` = 0. B is cleared to 0.
- `giris_hazir` is 0 while `rst` is high; input is ignored during reset.
- Reset mid-operation discards A and B contents. Blocks held in them are not counted.

## Timing
- Latency: 1 cycle. A block accepted at edge k is visible on the outputs after edge k, with `cikis_gecerli` high in cycle k+1.
- Throughput: 1 block per cycle while `cikis_hazir` is held high, with no bubbles.
- Stall recovery:
  - After a stall fills B, `giris_hazir` is low for exactly the cycles in DOLU.
  - The first `cikis_hazir` drains A and moves B into A in the same edge.
- Simultaneous input and output handshakes in TEK keep the occupancy constant.
- `giris_hazir` depends only on state and `rst`. It has no combinational path from `cikis_hazir`.
- `ters` may change on every beat. Mixed-mode streams stay ordered and correctly tagged.

## Structure
- Shared package `aes_paket`:
  - `NB_MIN`, `NB_MAX`.
  - Function `satir_ofset(nb, r)` returning the row offset.
  - Enum `durum_t` {BOS, TEK, DOLU}.
- One sub-module, `satir_kaydirma_nb`: combinational, parameter NB, inputs `matris` and `ters`, output shifted block. It is reusable by a future unrolled round core.
- The top level contains the FSM, registers A and B, and the counter.

## Test plan
- NB=4, forward, `cikis_hazir`=1.
  - Input: 00010203_04050607_08090a0b_0c0d0e0f.
  - Expected after 1 cycle: 00050a0f_04090e03_080d0207_0c01060b, `cikis_ters`=0.
- NB=4, inverse, same input.
  - Expected: 000d0a07_04010e0b_0805020f_0c090603, `cikis_ters`=1.
  - Check: feeding the forward result back in inverse mode returns the original.
- NB=8, forward, input bytes = 4c+r (00..1f).
  - Expected column 0 = 00050e13, column 1 = 04091217.
- Back-pressure: send 3 blocks back to back with `cikis_hazir`=0.
  - `giris_hazir` goes low after the 2nd accept, state DOLU, output frozen on block 1.
  - Release → blocks emerge in order 1, 2, 3, then `blok_sayisi`=3.
- Reset asserted in DOLU.
  - Next cycle: `cikis_gecerli`=0, outputs 0, `blok_sayisi`=0.
  - `giris_hazir`=1 one cycle after `rst` falls.
- Counter wrap: preload via 65535 handshakes (or force).
  - The next handshake gives `blok_sayisi`=0.
